// File: rtl/pfm_core_agent.sv
// pfm_core_agent: core-side prefetch monitor agent.
// Decode queue, retire delta coalescer and prediction serialiser.
module pfm_core_agent #(
  parameter int PCSIGN_W  = 13,
  parameter int ROBID_W   = 6,
  parameter int DECW_W    = 3,
  parameter int PFENTRY_W = 11,
  parameter int DELTA_W   = 16,
  parameter int WEIGHT_W  = 4,
  parameter int DEC_DEPTH = 4,
  parameter int FLUSH_TO  = 8,
  parameter int WMIN      = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_in_valid,
  output logic                 dec_in_retry,
  input  logic [PCSIGN_W-1:0]  dec_in_pcsign,
  input  logic [ROBID_W-1:0]   dec_in_rid,
  input  logic [DECW_W-1:0]    dec_in_decmask,
  output logic                 coretopfm_dec_valid,
  input  logic                 coretopfm_dec_retry,
  output logic [PCSIGN_W-1:0]  coretopfm_dec_pcsign,
  output logic [ROBID_W-1:0]   coretopfm_dec_rid,
  output logic [DECW_W-1:0]    coretopfm_dec_decmask,
  input  logic                 ret_in_valid,
  output logic                 ret_in_retry,
  input  logic [PFENTRY_W-1:0] ret_in_pfentry,
  input  logic [ROBID_W-1:0]   ret_in_rid,
  input  logic [DELTA_W-1:0]   ret_in_delta,
  output logic                 coretopfm_retire_valid,
  input  logic                 coretopfm_retire_retry,
  output logic [PFENTRY_W-1:0] coretopfm_retire_pfentry,
  output logic [ROBID_W-1:0]   coretopfm_retire_d0_rid,
  output logic [DELTA_W-1:0]   coretopfm_retire_d0_val,
  output logic [ROBID_W-1:0]   coretopfm_retire_d1_rid,
  output logic [DELTA_W-1:0]   coretopfm_retire_d1_val,
  output logic [ROBID_W-1:0]   coretopfm_retire_d2_rid,
  output logic [DELTA_W-1:0]   coretopfm_retire_d2_val,
  output logic [ROBID_W-1:0]   coretopfm_retire_d3_rid,
  output logic [DELTA_W-1:0]   coretopfm_retire_d3_val,
  input  logic                 pfmtocore_pred_valid,
  output logic                 pfmtocore_pred_retry,
  input  logic [PFENTRY_W-1:0] pfmtocore_pred_pfentry,
  input  logic [ROBID_W-1:0]   pfmtocore_pred_d0_rid,
  input  logic [DELTA_W-1:0]   pfmtocore_pred_d0_val,
  input  logic [WEIGHT_W-1:0]  pfmtocore_pred_d0_w,
  input  logic [ROBID_W-1:0]   pfmtocore_pred_d1_rid,
  input  logic [DELTA_W-1:0]   pfmtocore_pred_d1_val,
  input  logic [WEIGHT_W-1:0]  pfmtocore_pred_d1_w,
  input  logic [ROBID_W-1:0]   pfmtocore_pred_d2_rid,
  input  logic [DELTA_W-1:0]   pfmtocore_pred_d2_val,
  input  logic [WEIGHT_W-1:0]  pfmtocore_pred_d2_w,
  input  logic [ROBID_W-1:0]   pfmtocore_pred_d3_rid,
  input  logic [DELTA_W-1:0]   pfmtocore_pred_d3_val,
  input  logic [WEIGHT_W-1:0]  pfmtocore_pred_d3_w,
  output logic                 pf_req_valid,
  input  logic                 pf_req_retry,
  output logic [PFENTRY_W-1:0] pf_req_pfentry,
  output logic [ROBID_W-1:0]   pf_req_rid,
  output logic [DELTA_W-1:0]   pf_req_delta
);

  localparam int DPW = $clog2(DEC_DEPTH);
  localparam int FW  = $clog2(FLUSH_TO + 1);

  typedef struct packed {
    logic [PCSIGN_W-1:0] pcsign;
    logic [ROBID_W-1:0]  rid;
    logic [DECW_W-1:0]   decmask;
  } dec_t;

  typedef enum logic {IDLE, SEND} pstate_t;

  // ---------------- decode fifo ----------------
  dec_t           dec_mem [DEC_DEPTH];
  logic [DPW-1:0] dec_wr;
  logic [DPW-1:0] dec_rd;
  logic [DPW:0]   dec_cnt;
  logic           dec_full;
  logic           dec_push;
  logic           dec_pop;
  dec_t           dec_head;

  assign dec_full = dec_cnt == (DPW+1)'(DEC_DEPTH);
  assign dec_in_retry = dec_full;
  assign dec_push = dec_in_valid && !dec_full;
  assign coretopfm_dec_valid = dec_cnt != '0;
  assign dec_pop = coretopfm_dec_valid && !coretopfm_dec_retry;
  assign dec_head = coretopfm_dec_valid ? dec_mem[dec_rd] : '0;
  assign coretopfm_dec_pcsign  = dec_head.pcsign;
  assign coretopfm_dec_rid     = dec_head.rid;
  assign coretopfm_dec_decmask = dec_head.decmask;

  always_ff @(posedge clk) begin
    if (dec_push)
      dec_mem[dec_wr] <= '{dec_in_pcsign, dec_in_rid, dec_in_decmask};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_wr  <= '0;
      dec_rd  <= '0;
      dec_cnt <= '0;
    end else begin
      if (dec_push) dec_wr <= dec_wr + DPW'(1);
      if (dec_pop)  dec_rd <= dec_rd + DPW'(1);
      unique case ({dec_push, dec_pop})
        2'b10:   dec_cnt <= dec_cnt + (DPW+1)'(1);
        2'b01:   dec_cnt <= dec_cnt - (DPW+1)'(1);
        default: dec_cnt <= dec_cnt;
      endcase
    end
  end

  // ---------------- retire coalescer ----------------
  logic [PFENTRY_W-1:0] asm_pfentry;
  logic [2:0]           asm_cnt;
  logic [ROBID_W-1:0]   asm_rid [4];
  logic [DELTA_W-1:0]   asm_val [4];
  logic [FW-1:0]        flush_cnt;

  logic [PFENTRY_W-1:0] out_pfentry;
  logic [ROBID_W-1:0]   out_rid [4];
  logic [DELTA_W-1:0]   out_val [4];

  logic               fill;
  logic               mismatch;
  logic               timeout_close;
  logic               last_fill;
  logic               close_req;
  logic               out_free;
  logic               close_fire;
  logic               accept;
  logic [ROBID_W-1:0] pkt_rid [4];
  logic [DELTA_W-1:0] pkt_val [4];

  always_comb begin
    fill = ret_in_valid && ret_in_delta != '0 &&
           (asm_cnt == 3'd0 || ret_in_pfentry == asm_pfentry);
    mismatch = ret_in_valid && ret_in_delta != '0 && asm_cnt != 3'd0 &&
               ret_in_pfentry != asm_pfentry;
    // an accept in the timeout cycle counts as activity, so no flush
    timeout_close = !ret_in_valid && asm_cnt != 3'd0 &&
                    flush_cnt == FW'(FLUSH_TO);
    last_fill  = fill && asm_cnt == 3'd3;
    close_req  = mismatch || timeout_close || last_fill;
    out_free   = !coretopfm_retire_valid || !coretopfm_retire_retry;
    close_fire = close_req && out_free;
    ret_in_retry = close_req && !out_free;
    accept = ret_in_valid && !ret_in_retry;
    for (int i = 0; i < 4; i++) begin
      pkt_rid[i] = asm_rid[i];
      pkt_val[i] = asm_val[i];
    end
    if (last_fill) begin
      pkt_rid[3] = ret_in_rid;
      pkt_val[3] = ret_in_delta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_pfentry <= '0;
      asm_cnt     <= '0;
      flush_cnt   <= '0;
      for (int i = 0; i < 4; i++) begin
        asm_rid[i] <= '0;
        asm_val[i] <= '0;
      end
    end else begin
      if (accept)
        flush_cnt <= '0;
      else if (flush_cnt != FW'(FLUSH_TO))
        flush_cnt <= flush_cnt + FW'(1);
      if (close_fire) begin
        for (int i = 0; i < 4; i++) begin
          asm_rid[i] <= '0;
          asm_val[i] <= '0;
        end
        if (mismatch) begin
          asm_pfentry <= ret_in_pfentry;
          asm_cnt     <= 3'd1;
          asm_rid[0]  <= ret_in_rid;
          asm_val[0]  <= ret_in_delta;
        end else begin
          asm_pfentry <= '0;
          asm_cnt     <= '0;
        end
      end else if (accept && fill) begin
        asm_pfentry          <= ret_in_pfentry;
        asm_cnt              <= asm_cnt + 3'd1;
        asm_rid[asm_cnt[1:0]] <= ret_in_rid;
        asm_val[asm_cnt[1:0]] <= ret_in_delta;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coretopfm_retire_valid <= 1'b0;
      out_pfentry <= '0;
      for (int i = 0; i < 4; i++) begin
        out_rid[i] <= '0;
        out_val[i] <= '0;
      end
    end else if (close_fire) begin
      coretopfm_retire_valid <= 1'b1;
      out_pfentry <= asm_pfentry;
      for (int i = 0; i < 4; i++) begin
        out_rid[i] <= pkt_rid[i];
        out_val[i] <= pkt_val[i];
      end
    end else if (coretopfm_retire_valid && !coretopfm_retire_retry) begin
      coretopfm_retire_valid <= 1'b0;
      out_pfentry <= '0;
      for (int i = 0; i < 4; i++) begin
        out_rid[i] <= '0;
        out_val[i] <= '0;
      end
    end
  end

  assign coretopfm_retire_pfentry = out_pfentry;
  assign coretopfm_retire_d0_rid = out_rid[0];
  assign coretopfm_retire_d0_val = out_val[0];
  assign coretopfm_retire_d1_rid = out_rid[1];
  assign coretopfm_retire_d1_val = out_val[1];
  assign coretopfm_retire_d2_rid = out_rid[2];
  assign coretopfm_retire_d2_val = out_val[2];
  assign coretopfm_retire_d3_rid = out_rid[3];
  assign coretopfm_retire_d3_val = out_val[3];

  // ---------------- prediction serialiser ----------------
  logic [ROBID_W-1:0]  in_rid [4];
  logic [DELTA_W-1:0]  in_val [4];
  logic [WEIGHT_W-1:0] in_w   [4];
  logic [3:0]          in_mask;

  assign in_rid[0] = pfmtocore_pred_d0_rid;
  assign in_rid[1] = pfmtocore_pred_d1_rid;
  assign in_rid[2] = pfmtocore_pred_d2_rid;
  assign in_rid[3] = pfmtocore_pred_d3_rid;
  assign in_val[0] = pfmtocore_pred_d0_val;
  assign in_val[1] = pfmtocore_pred_d1_val;
  assign in_val[2] = pfmtocore_pred_d2_val;
  assign in_val[3] = pfmtocore_pred_d3_val;
  assign in_w[0]   = pfmtocore_pred_d0_w;
  assign in_w[1]   = pfmtocore_pred_d1_w;
  assign in_w[2]   = pfmtocore_pred_d2_w;
  assign in_w[3]   = pfmtocore_pred_d3_w;

  always_comb begin
    for (int i = 0; i < 4; i++)
      in_mask[i] = in_w[i] >= WEIGHT_W'(WMIN) && in_val[i] != '0;
  end

  pstate_t              state;
  pstate_t              state_n;
  logic [3:0]           p_mask;
  logic [3:0]           mask_n;
  logic [3:0]           low;
  logic [1:0]           sel;
  logic                 cap;
  logic [PFENTRY_W-1:0] p_pfentry;
  logic [ROBID_W-1:0]   p_rid [4];
  logic [DELTA_W-1:0]   p_val [4];

  always_comb begin
    low = p_mask & (~p_mask + 4'd1);
    unique case (1'b1)
      low[1]:  sel = 2'd1;
      low[2]:  sel = 2'd2;
      low[3]:  sel = 2'd3;
      default: sel = 2'd0;
    endcase
  end

  always_comb begin
    state_n = state;
    mask_n  = p_mask;
    cap     = 1'b0;
    pfmtocore_pred_retry = state == SEND;
    pf_req_valid         = state == SEND;
    unique case (state)
      IDLE: begin
        if (pfmtocore_pred_valid) begin
          cap = 1'b1;
          if (in_mask != 4'd0) state_n = SEND;
        end
      end
      SEND: begin
        if (!pf_req_retry) begin
          mask_n = p_mask & ~low;
          if (mask_n == 4'd0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      p_mask    <= '0;
      p_pfentry <= '0;
      for (int i = 0; i < 4; i++) begin
        p_rid[i] <= '0;
        p_val[i] <= '0;
      end
    end else begin
      state  <= state_n;
      p_mask <= cap ? in_mask : mask_n;
      if (cap) begin
        p_pfentry <= pfmtocore_pred_pfentry;
        for (int i = 0; i < 4; i++) begin
          p_rid[i] <= in_rid[i];
          p_val[i] <= in_val[i];
        end
      end
    end
  end

  assign pf_req_pfentry = pf_req_valid ? p_pfentry : '0;
  assign pf_req_rid     = pf_req_valid ? p_rid[sel] : '0;
  assign pf_req_delta   = pf_req_valid ? p_val[sel] : '0;

endmodule

// File: tb/tb_pfm_core_agent.sv
// tb_pfm_core_agent: directed self-checking bench for pfm_core_agent.
// Inputs change 1ns after posedge; outputs sampled there too.
module tb_pfm_core_agent;
  logic clk = 1'b0;
  logic reset;
  logic dec_in_valid, dec_in_retry;
  logic [12:0] dec_in_pcsign;
  logic [5:0] dec_in_rid;
  logic [2:0] dec_in_decmask;
  logic dec_valid, dec_retry;
  logic [12:0] dec_pcsign;
  logic [5:0] dec_rid;
  logic [2:0] dec_decmask;
  logic ret_in_valid, ret_in_retry;
  logic [10:0] ret_in_pfentry;
  logic [5:0] ret_in_rid;
  logic [15:0] ret_in_delta;
  logic rt_valid, rt_retry;
  logic [10:0] rt_pfentry;
  logic [5:0] rt_rid0, rt_rid1, rt_rid2, rt_rid3;
  logic [15:0] rt_val0, rt_val1, rt_val2, rt_val3;
  logic pr_valid, pr_retry;
  logic [10:0] pr_pfentry;
  logic [5:0] pr_rid0, pr_rid1, pr_rid2, pr_rid3;
  logic [15:0] pr_val0, pr_val1, pr_val2, pr_val3;
  logic [3:0] pr_w0, pr_w1, pr_w2, pr_w3;
  logic pf_valid, pf_retry;
  logic [10:0] pf_pfentry;
  logic [5:0] pf_rid;
  logic [15:0] pf_delta;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int n;
  int seen;

  pfm_core_agent dut (
    .clk(clk), .reset(reset),
    .dec_in_valid(dec_in_valid), .dec_in_retry(dec_in_retry),
    .dec_in_pcsign(dec_in_pcsign), .dec_in_rid(dec_in_rid),
    .dec_in_decmask(dec_in_decmask),
    .coretopfm_dec_valid(dec_valid), .coretopfm_dec_retry(dec_retry),
    .coretopfm_dec_pcsign(dec_pcsign), .coretopfm_dec_rid(dec_rid),
    .coretopfm_dec_decmask(dec_decmask),
    .ret_in_valid(ret_in_valid), .ret_in_retry(ret_in_retry),
    .ret_in_pfentry(ret_in_pfentry), .ret_in_rid(ret_in_rid),
    .ret_in_delta(ret_in_delta),
    .coretopfm_retire_valid(rt_valid), .coretopfm_retire_retry(rt_retry),
    .coretopfm_retire_pfentry(rt_pfentry),
    .coretopfm_retire_d0_rid(rt_rid0), .coretopfm_retire_d0_val(rt_val0),
    .coretopfm_retire_d1_rid(rt_rid1), .coretopfm_retire_d1_val(rt_val1),
    .coretopfm_retire_d2_rid(rt_rid2), .coretopfm_retire_d2_val(rt_val2),
    .coretopfm_retire_d3_rid(rt_rid3), .coretopfm_retire_d3_val(rt_val3),
    .pfmtocore_pred_valid(pr_valid), .pfmtocore_pred_retry(pr_retry),
    .pfmtocore_pred_pfentry(pr_pfentry),
    .pfmtocore_pred_d0_rid(pr_rid0), .pfmtocore_pred_d0_val(pr_val0),
    .pfmtocore_pred_d0_w(pr_w0),
    .pfmtocore_pred_d1_rid(pr_rid1), .pfmtocore_pred_d1_val(pr_val1),
    .pfmtocore_pred_d1_w(pr_w1),
    .pfmtocore_pred_d2_rid(pr_rid2), .pfmtocore_pred_d2_val(pr_val2),
    .pfmtocore_pred_d2_w(pr_w2),
    .pfmtocore_pred_d3_rid(pr_rid3), .pfmtocore_pred_d3_val(pr_val3),
    .pfmtocore_pred_d3_w(pr_w3),
    .pf_req_valid(pf_valid), .pf_req_retry(pf_retry),
    .pf_req_pfentry(pf_pfentry), .pf_req_rid(pf_rid),
    .pf_req_delta(pf_delta)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [5:0]  t_rid [4];
  logic [15:0] t_dlt [4];

  initial begin
    reset = 1'b0;
    {dec_in_valid, dec_in_pcsign, dec_in_rid, dec_in_decmask} = '0;
    {ret_in_valid, ret_in_pfentry, ret_in_rid, ret_in_delta} = '0;
    {pr_valid, pr_pfentry} = '0;
    {pr_rid0, pr_rid1, pr_rid2, pr_rid3} = '0;
    {pr_val0, pr_val1, pr_val2, pr_val3} = '0;
    {pr_w0, pr_w1, pr_w2, pr_w3} = '0;
    dec_retry = 1'b0; rt_retry = 1'b0; pf_retry = 1'b0;
    #2;
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_rt_valid", rt_valid, 0);
    chk("rst_pf_valid", pf_valid, 0);
    chk("rst_retries", {dec_in_retry, ret_in_retry, pr_retry}, 0);
    chk("rst_payload", {rt_pfentry, rt_val0, pf_delta, dec_rid}, 0);
    step();
    reset = 1'b1;

    // decode: fill past depth with downstream stalled
    dec_retry = 1'b1;
    dec_in_valid = 1'b1;
    dec_in_rid = 6'd1; dec_in_pcsign = 13'h101; dec_in_decmask = 3'd1;
    step();
    chk("dec_lat1_valid", dec_valid, 1);
    chk("dec_lat1_rid", dec_rid, 1);
    chk("dec_lat1_pcsign", dec_pcsign, 13'h101);
    chk("dec_not_full", dec_in_retry, 0);
    for (int k = 2; k <= 5; k++) begin
      dec_in_rid = 6'(k);
      dec_in_pcsign = 13'(12'h100 + k);
      dec_in_decmask = 3'(k);
      step();
    end
    chk("dec_full_retry", dec_in_retry, 1);
    chk("dec_head_held", dec_rid, 1);
    dec_retry = 1'b0;
    step();
    chk("dec_out2", dec_rid, 2);
    step();
    dec_in_valid = 1'b0;
    chk("dec_out3", dec_rid, 3);
    step();
    chk("dec_out4", dec_rid, 4);
    step();
    chk("dec_out5", dec_rid, 5);
    chk("dec_out5_pcsign", dec_pcsign, 13'h105);
    chk("dec_out5_mask", dec_decmask, 5);
    step();
    chk("dec_empty", dec_valid, 0);

    // retire: full 4-slot packet
    t_rid[0] = 3; t_rid[1] = 4; t_rid[2] = 5; t_rid[3] = 6;
    t_dlt[0] = 16'd8; t_dlt[1] = 16'hFFF8;
    t_dlt[2] = 16'd16; t_dlt[3] = 16'd64;
    for (int i = 0; i < 4; i++) begin
      ret_in_valid = 1'b1; ret_in_pfentry = 11'h12;
      ret_in_rid = t_rid[i]; ret_in_delta = t_dlt[i];
      step();
      if (i < 3) chk("rt4_early_valid", rt_valid, 0);
    end
    ret_in_valid = 1'b0;
    chk("rt4_valid", rt_valid, 1);
    chk("rt4_pfentry", rt_pfentry, 11'h12);
    chk("rt4_rids", {rt_rid0, rt_rid1, rt_rid2, rt_rid3},
        {6'd3, 6'd4, 6'd5, 6'd6});
    chk("rt4_v0", rt_val0, 16'd8);
    chk("rt4_v1", rt_val1, 16'hFFF8);
    chk("rt4_v2", rt_val2, 16'd16);
    chk("rt4_v3", rt_val3, 16'd64);
    step();
    chk("rt4_drained", rt_valid, 0);

    // retire: pfentry change closes, then idle flush
    ret_in_valid = 1'b1; ret_in_pfentry = 11'h12;
    ret_in_rid = 6'd1; ret_in_delta = 16'd4;
    step();
    ret_in_pfentry = 11'h20; ret_in_rid = 6'd2;
    step();
    ret_in_valid = 1'b0;
    chk("rtm_valid", rt_valid, 1);
    chk("rtm_pfentry", rt_pfentry, 11'h12);
    chk("rtm_slot0", {rt_rid0, rt_val0}, {6'd1, 16'd4});
    chk("rtm_rest", {rt_rid1, rt_val1, rt_rid2, rt_val2, rt_rid3, rt_val3}, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!rt_valid && n < 20);
    chk("rtf_delay", n, 9);
    chk("rtf_pfentry", rt_pfentry, 11'h20);
    chk("rtf_slot0", {rt_rid0, rt_val0}, {6'd2, 16'd4});
    chk("rtf_slot1", {rt_rid1, rt_val1}, 0);
    step();

    // prediction: weight filter and stalled request
    pr_valid = 1'b1; pr_pfentry = 11'h55;
    pr_rid0 = 6'd10; pr_val0 = 16'd100;    pr_w0 = 4'd2;
    pr_rid1 = 6'd11; pr_val1 = 16'hFED4;   pr_w1 = 4'd7;
    pr_rid2 = 6'd12; pr_val2 = 16'd5;      pr_w2 = 4'd4;
    pr_rid3 = 6'd13; pr_val3 = 16'h7FFF;   pr_w3 = 4'd15;
    chk("pr_idle_retry", pr_retry, 0);
    step();
    pr_valid = 1'b0;
    chk("pf1_valid", pf_valid, 1);
    chk("pf1_pfentry", pf_pfentry, 11'h55);
    chk("pf1_rid", pf_rid, 11);
    chk("pf1_delta", pf_delta, 16'hFED4);
    chk("pf1_predretry", pr_retry, 1);
    step();
    chk("pf2_rid", pf_rid, 12);
    chk("pf2_delta", pf_delta, 16'd5);
    pf_retry = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("pf2_hold", {pf_valid, pf_rid, pr_retry}, {1'b1, 6'd12, 1'b1});
    end
    pf_retry = 1'b0;
    step();
    chk("pf3_rid", pf_rid, 13);
    chk("pf3_delta", pf_delta, 16'h7FFF);
    step();
    chk("pf_done_valid", pf_valid, 0);
    chk("pf_done_predretry", pr_retry, 0);

    // prediction: all weights low, then next accepted at once
    pr_valid = 1'b1; pr_pfentry = 11'h66;
    pr_w0 = 4'd0; pr_w1 = 4'd1; pr_w2 = 4'd2; pr_w3 = 4'd3;
    step();
    chk("prlow_no_req", pf_valid, 0);
    chk("prlow_retry", pr_retry, 0);
    pr_pfentry = 11'h77;
    pr_rid0 = 6'd20; pr_val0 = 16'd9; pr_w0 = 4'd4;
    pr_w1 = 4'd0; pr_w2 = 4'd0; pr_w3 = 4'd3;
    step();
    pr_valid = 1'b0;
    chk("prnext_req", {pf_valid, pf_pfentry}, {1'b1, 11'h77});
    chk("prnext_slot", {pf_rid, pf_delta}, {6'd20, 16'd9});
    step();
    chk("prnext_done", pf_valid, 0);

    // reset with stalled retire output and queued decodes
    rt_retry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ret_in_valid = 1'b1; ret_in_pfentry = 11'h30;
      ret_in_rid = 6'(i + 1); ret_in_delta = 16'(i + 1);
      step();
    end
    ret_in_pfentry = 11'h31; ret_in_rid = 6'd7; ret_in_delta = 16'd2;
    step();
    chk("rs_partial_accepted", ret_in_retry, 0);
    ret_in_valid = 1'b0;
    dec_retry = 1'b1;
    dec_in_valid = 1'b1; dec_in_rid = 6'd9;
    step();
    dec_in_rid = 6'd10;
    step();
    dec_in_valid = 1'b0;
    chk("rs_pre_valids", {rt_valid, dec_valid}, 2'b11);
    #2;
    reset = 1'b0;
    #1;
    chk("rs_valids", {dec_valid, rt_valid, pf_valid}, 0);
    chk("rs_retries", {dec_in_retry, ret_in_retry, pr_retry}, 0);
    chk("rs_payload", {rt_pfentry, rt_rid0, dec_rid}, 0);
    step();
    reset = 1'b1;
    rt_retry = 1'b0;
    dec_retry = 1'b0;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (rt_valid || dec_valid) seen++;
    end
    chk("rs_no_stale", seen, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
